// File: rtl/bp_stream_pump_out_mc_pkg.sv
// Shared types for the multi-channel stream pump: mem header layout, payload masks, pump state.
package bp_stream_pump_out_mc_pkg;

  localparam int paddr_width_gp = 40;

  typedef enum logic [3:0] {
    e_mem_msg_rd    = 4'd0,
    e_mem_msg_wr    = 4'd1,
    e_mem_msg_uc_rd = 4'd2,
    e_mem_msg_uc_wr = 4'd3,
    e_mem_msg_pre   = 4'd4
  } mem_msg_e;

  // Commands carry data on writes; responses carry data on reads.
  localparam logic [15:0] mem_cmd_payload_mask_gp  = 16'b1010;
  localparam logic [15:0] mem_resp_payload_mask_gp = 16'b0101;

  typedef struct packed {
    logic [7:0]                payload;
    logic [2:0]                size;
    logic [paddr_width_gp-1:0] addr;
    mem_msg_e                  msg_type;
  } mem_header_s;

  localparam int mem_header_width_gp = $bits(mem_header_s);

  typedef enum logic {e_idle, e_stream} pump_state_e;

  // Beats needed for a 2^size byte message, never less than one.
  function automatic logic [7:0] beats_for_size(input logic [2:0] size, input logic [2:0] beat_lg);
    logic [7:0] b;
    b = (8'(1) << size) >> beat_lg;
    return (b == 8'd0) ? 8'd1 : b;
  endfunction

endpackage

// File: rtl/bp_stream_pump_out_mc_beat_counter.sv
// Wrapping beat counter; shows first_cnt while idle and flags the message's last beat.
module bp_stream_pump_out_mc_beat_counter #(
  parameter int len_w_p = 3
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               set_i,
  input  logic               en_i,
  input  logic               clear_i,
  input  logic               use_first_i,
  input  logic [len_w_p-1:0] first_cnt_i,
  input  logic [len_w_p:0]   num_stream_i,
  output logic [len_w_p-1:0] cnt_o,
  output logic               last_o
);

  logic [len_w_p-1:0] cnt_r, last_cnt;

  // Truncation makes the last index wrap around the block.
  assign last_cnt = first_cnt_i + num_stream_i[len_w_p-1:0] - len_w_p'(1);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)      cnt_r <= '0;
    else if (clear_i) cnt_r <= '0;
    else if (set_i)   cnt_r <= first_cnt_i + len_w_p'(1);
    else if (en_i)    cnt_r <= cnt_r + len_w_p'(1);
  end

  assign cnt_o  = use_first_i ? first_cnt_i : cnt_r;
  assign last_o = (cnt_o == last_cnt);

endmodule

// File: rtl/bp_stream_pump_out_mc.sv
// N-channel round-robin stream pump onto one mem stream with wrapping beat addresses and ack combining.
// Define BP_STREAM_PUMP_OUT_MC_HEADER_LATCH_EN to register the granted header on the first handshake.
module bp_stream_pump_out_mc
  import bp_stream_pump_out_mc_pkg::*;
#(
  parameter int          channels_p          = 2,
  parameter int          stream_data_width_p = 64,
  parameter int          block_width_p       = 512,
  parameter logic [15:0] payload_mask_p      = 16'h0,
  localparam int         stream_words_lp     = block_width_p / stream_data_width_p,
  localparam int         cnt_w_lp            = $clog2(stream_words_lp),
  localparam int         hdr_w               = mem_header_width_gp
) (
  input  logic                                          clk_i,
  input  logic                                          reset_i,
  output logic [hdr_w-1:0]                              mem_header_o,
  output logic [stream_data_width_p-1:0]                mem_data_o,
  output logic                                          mem_v_o,
  output logic                                          mem_lock_o,
  input  logic                                          mem_yumi_i,
  input  logic [channels_p-1:0][hdr_w-1:0]              fsm_base_header_i,
  input  logic [channels_p-1:0][stream_data_width_p-1:0] fsm_data_i,
  input  logic [channels_p-1:0]                         fsm_v_i,
  output logic [channels_p-1:0]                         fsm_yumi_o,
  output logic [channels_p-1:0]                         grant_o,
  output logic [cnt_w_lp-1:0]                           cnt_o,
  output logic                                          done_o
);

  localparam int   offset_lp    = $clog2(stream_data_width_p/8);
  localparam int   ch_w_lp      = (channels_p > 1) ? $clog2(channels_p) : 1;
  localparam logic is_master_lp = (payload_mask_p == mem_cmd_payload_mask_gp);

  pump_state_e          state_r, state_n;
  logic [ch_w_lp-1:0]   rr_ptr_r, grant_r, pick_idx, sel_idx;
  logic                 pick_v, granted, in_stream, en_out;
  mem_header_s          live_hdr, base_hdr, out_hdr;
  logic [hdr_w-1:0]     out_bits;
  logic                 has_data, single, fsm_v, is_last;
  logic                 mem_v, yumi, lock, done;
  logic                 cnt_set, cnt_en, cnt_clr;
  logic [7:0]           beats;
  logic [cnt_w_lp:0]    num_stream;
  logic [cnt_w_lp-1:0]  first_cnt, cnt;

  assign in_stream = (state_r == e_stream);

  // First valid channel at or after the pointer wins; scanning downward lets the nearest override.
  always_comb begin
    pick_idx = '0;
    pick_v   = 1'b0;
    for (int i = channels_p-1; i >= 0; i--) begin
      if (fsm_v_i[(int'(rr_ptr_r) + i) % channels_p]) begin
        pick_v   = 1'b1;
        pick_idx = ch_w_lp'((int'(rr_ptr_r) + i) % channels_p);
      end
    end
  end

  assign sel_idx  = in_stream ? grant_r : pick_idx;
  assign granted  = in_stream | pick_v;
  assign live_hdr = fsm_base_header_i[sel_idx];

`ifdef BP_STREAM_PUMP_OUT_MC_HEADER_LATCH_EN
  mem_header_s hdr_r;
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)      hdr_r <= '0;
    else if (cnt_set) hdr_r <= live_hdr;
  end
  assign base_hdr = in_stream ? hdr_r : live_hdr;
`else
  assign base_hdr = live_hdr;
`endif

  assign has_data   = payload_mask_p[base_hdr.msg_type];
  assign beats      = beats_for_size(base_hdr.size, 3'(offset_lp));
  assign num_stream = (beats > 8'(stream_words_lp)) ? (cnt_w_lp+1)'(stream_words_lp) : beats[cnt_w_lp:0];
  assign first_cnt  = base_hdr.addr[offset_lp +: cnt_w_lp];
  assign single     = ~in_stream & ((num_stream == (cnt_w_lp+1)'(1)) | (is_master_lp & ~has_data));
  assign fsm_v      = fsm_v_i[sel_idx] & granted;

  bp_stream_pump_out_mc_beat_counter #(.len_w_p(cnt_w_lp)) u_cnt (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .set_i        (cnt_set),
    .en_i         (cnt_en),
    .clear_i      (cnt_clr),
    .use_first_i  (~in_stream),
    .first_cnt_i  (first_cnt),
    .num_stream_i (num_stream),
    .cnt_o        (cnt),
    .last_o       (is_last)
  );

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state_r <= e_idle;
    else         state_r <= state_n;
  end

  always_comb begin
    state_n = state_r;
    case (state_r)
      e_idle:   if (cnt_set) state_n = e_stream;
      e_stream: if (done)    state_n = e_idle;
      default:  state_n = e_idle;
    endcase
  end

  // Data-less multi-beat messages retire early beats locally and send one combined ack.
  always_comb begin
    mem_v = 1'b0;
    yumi  = 1'b0;
    lock  = 1'b0;
    if (granted) begin
      if (single | has_data) begin
        mem_v = fsm_v;
        yumi  = fsm_v & mem_yumi_i;
        lock  = ~single & ~is_last;
      end else begin
        mem_v = fsm_v & is_last;
        yumi  = is_last ? (fsm_v & mem_yumi_i) : fsm_v;
      end
    end
    done    = yumi & (single | is_last);
    cnt_set = ~in_stream & yumi & ~single;
    cnt_en  = in_stream & yumi & ~is_last;
    cnt_clr = in_stream & done;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rr_ptr_r <= '0;
      grant_r  <= '0;
    end else begin
      if (done)    rr_ptr_r <= (int'(sel_idx) == channels_p-1) ? '0 : sel_idx + 1'b1;
      if (cnt_set) grant_r  <= pick_idx;
    end
  end

  always_comb begin
    out_hdr = base_hdr;
    out_hdr.addr[offset_lp +: cnt_w_lp] = cnt;
  end
  assign out_bits = out_hdr;

  assign en_out       = granted & ~reset_i;
  assign mem_header_o = en_out ? out_bits : '0;
  assign mem_data_o   = en_out ? fsm_data_i[sel_idx] : '0;
  assign mem_v_o      = mem_v & ~reset_i;
  assign mem_lock_o   = lock & ~reset_i;
  assign done_o       = done & ~reset_i;
  assign cnt_o        = en_out ? cnt : '0;

  always_comb begin
    grant_o    = '0;
    fsm_yumi_o = '0;
    if (en_out) begin
      grant_o[sel_idx]    = 1'b1;
      fsm_yumi_o[sel_idx] = yumi;
    end
  end

endmodule

// File: tb/tb_bp_stream_pump_out_mc.sv
// Bench: a master-side and a client-side pump checked every cycle against a message-level model.
module tb_bp_stream_pump_out_mc;
  import bp_stream_pump_out_mc_pkg::*;

  localparam int NCH = 2;
  localparam int DW  = 64;
  localparam int HW  = mem_header_width_gp;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [HW-1:0]           mem_header [2];
  logic [DW-1:0]           mem_data   [2];
  logic                    mem_v [2], mem_lock [2], mem_yumi [2], done [2];
  logic [NCH-1:0][HW-1:0]  fsm_hdr  [2];
  logic [NCH-1:0][DW-1:0]  fsm_data [2];
  logic [NCH-1:0]          fsm_v [2], fsm_yumi [2], grant [2];
  logic [2:0]              cnt [2];

  bp_stream_pump_out_mc #(.channels_p(NCH), .stream_data_width_p(DW), .block_width_p(512),
                          .payload_mask_p(mem_cmd_payload_mask_gp)) u_mst (
    .clk_i(clk), .reset_i(rst), .mem_header_o(mem_header[0]), .mem_data_o(mem_data[0]),
    .mem_v_o(mem_v[0]), .mem_lock_o(mem_lock[0]), .mem_yumi_i(mem_yumi[0]),
    .fsm_base_header_i(fsm_hdr[0]), .fsm_data_i(fsm_data[0]), .fsm_v_i(fsm_v[0]),
    .fsm_yumi_o(fsm_yumi[0]), .grant_o(grant[0]), .cnt_o(cnt[0]), .done_o(done[0]));

  bp_stream_pump_out_mc #(.channels_p(NCH), .stream_data_width_p(DW), .block_width_p(512),
                          .payload_mask_p(mem_resp_payload_mask_gp)) u_cli (
    .clk_i(clk), .reset_i(rst), .mem_header_o(mem_header[1]), .mem_data_o(mem_data[1]),
    .mem_v_o(mem_v[1]), .mem_lock_o(mem_lock[1]), .mem_yumi_i(mem_yumi[1]),
    .fsm_base_header_i(fsm_hdr[1]), .fsm_data_i(fsm_data[1]), .fsm_v_i(fsm_v[1]),
    .fsm_yumi_o(fsm_yumi[1]), .grant_o(grant[1]), .cnt_o(cnt[1]), .done_o(done[1]));

  // Message table per instance/channel and the arbitration model.
  mem_msg_e    m_typ  [2][NCH];
  logic [2:0]  m_size [2][NCH];
  logic [39:0] m_addr [2][NCH];
  int          m_id   [2][NCH];
  int          m_done [2][NCH];
  bit          m_act  [2][NCH];
  int          own [2], ptr [2];
  logic [15:0] mask [2];
  bit          is_mst [2];

  int  n_chk = 0, n_pass = 0, cyc = 0, next_id = 1;
  bit  rand_en = 0, v_all = 1, yumi_all = 1, rst_req = 1;
  int  log_sel = -1, comb_cnt = 0;
  logic [39:0] lq_addr [$];
  bit          lq_lock [$], lq_done [$];
  int          lq_gnt  [$], lq_cyc [$];

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
  endtask

  function automatic int n_beats(logic [2:0] s);
    int b = (1 << s) / 8;
    if (b < 1) b = 1;
    if (b > 8) b = 8;
    return b;
  endfunction

  function automatic logic [63:0] beat_data(int i, int c, int id, int k);
    return {8'(i), 8'(c), 16'(id), 32'(k)};
  endfunction

  function automatic mem_header_s mk_hdr(int i, int c);
    mem_header_s h;
    h.payload = 8'(m_id[i][c]);
    h.size = m_size[i][c];
    h.addr = m_addr[i][c];
    h.msg_type = m_typ[i][c];
    return h;
  endfunction

  task automatic load(int i, int c, mem_msg_e t, logic [2:0] s, logic [39:0] a);
    m_typ[i][c] = t; m_size[i][c] = s; m_addr[i][c] = a;
    m_id[i][c] = next_id++; m_done[i][c] = 0; m_act[i][c] = 1;
  endtask

  task automatic clear_log(int i);
    log_sel = i; comb_cnt = 0;
    lq_addr.delete(); lq_lock.delete(); lq_done.delete(); lq_gnt.delete(); lq_cyc.delete();
  endtask

  task automatic check_inst(int i);
    int g = -1;
    int n, k;
    bit hd, single, fv, last, yum, mv, dn, lk;
    logic [NCH-1:0] ey, eg;
    logic [2:0] ecnt;
    mem_header_s eh;
    mv = 0; yum = 0; dn = 0; lk = 0; ey = '0; eg = '0; ecnt = '0; single = 0; eh = '0; k = 0;
    if (!rst) begin
      if (own[i] >= 0) g = own[i];
      else for (int j = 0; j < NCH; j++) begin
        int c = (ptr[i] + j) % NCH;
        if (g < 0 && fsm_v[i][c]) g = c;
      end
    end
    if (g >= 0) begin
      n = n_beats(m_size[i][g]);
      hd = mask[i][m_typ[i][g]];
      single = (own[i] < 0) && (n == 1 || (is_mst[i] && !hd));
      k = m_done[i][g];
      ecnt = 3'((m_addr[i][g][5:3] + k) % 8);
      last = single || (k == n - 1);
      fv = fsm_v[i][g];
      if (hd || single) begin
        mv = fv; yum = fv && mem_yumi[i]; lk = !last;
      end else begin
        mv = fv && last; yum = last ? (fv && mem_yumi[i]) : fv;
      end
      dn = yum && last;
      eg[g] = 1'b1; ey[g] = yum;
      eh = mk_hdr(i, g); eh.addr[5:3] = ecnt;
    end
    chk($sformatf("grant%0d", i), 64'(grant[i]), 64'(eg));
    chk($sformatf("cnt%0d", i), 64'(cnt[i]), 64'(ecnt));
    chk($sformatf("mem_v%0d", i), 64'(mem_v[i]), 64'(mv));
    chk($sformatf("fsm_yumi%0d", i), 64'(fsm_yumi[i]), 64'(ey));
    chk($sformatf("done%0d", i), 64'(done[i]), 64'(dn));
    chk($sformatf("lock%0d", i), 64'(mem_lock[i]), 64'(lk));
    if (mv) begin
      chk($sformatf("hdr%0d", i), 64'(mem_header[i]), 64'(eh));
      chk($sformatf("data%0d", i), mem_data[i], beat_data(i, g, m_id[i][g], k));
    end
    if (log_sel == i) begin
      mem_header_s ah;
      ah = mem_header[i];
      if (mem_v[i] && mem_yumi[i]) begin
        lq_addr.push_back(ah.addr); lq_lock.push_back(mem_lock[i]); lq_done.push_back(done[i]);
        lq_gnt.push_back(grant[i][1] ? 1 : 0); lq_cyc.push_back(cyc);
      end
      if (fsm_yumi[i] != '0 && !mem_v[i]) comb_cnt++;
    end
    if (rst) begin
      own[i] = -1; ptr[i] = 0;
      for (int c = 0; c < NCH; c++) m_done[i][c] = 0;
    end else if (g >= 0) begin
      if (yum) begin
        m_done[i][g]++;
        if (own[i] < 0 && !single) own[i] = g;
      end
      if (dn) begin
        own[i] = -1; ptr[i] = (g + 1) % NCH; m_act[i][g] = 0;
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk); #1;
    rst = rst_req;
    cyc++;
    for (int i = 0; i < 2; i++) begin
      for (int c = 0; c < NCH; c++) begin
        mem_header_s h;
        if (!rst && rand_en && !m_act[i][c] && $urandom_range(3) == 0)
          load(i, c, mem_msg_e'($urandom_range(0, 3)),
               ($urandom_range(1) == 1) ? 3'd6 : 3'($urandom_range(0, 5)), {24'h0, 16'($urandom)});
        fsm_v[i][c] = m_act[i][c] && (v_all || $urandom_range(3) != 0);
        h = mk_hdr(i, c);
`ifdef BP_STREAM_PUMP_OUT_MC_HEADER_LATCH_EN
        if (m_done[i][c] > 0) h.addr = h.addr ^ (40'($urandom_range(1, 255)) << 3);
`endif
        fsm_hdr[i][c] = h;
        fsm_data[i][c] = beat_data(i, c, m_id[i][c], m_done[i][c]);
      end
    end
    #1;
    for (int i = 0; i < 2; i++) mem_yumi[i] = mem_v[i] && (yumi_all || $urandom_range(3) != 0);
    @(negedge clk);
    check_inst(0);
    check_inst(1);
  endtask

  task automatic drain(int limit);
    int busy = 1;
    for (int t = 0; t < limit && busy != 0; t++) begin
      cycle();
      busy = 0;
      for (int i = 0; i < 2; i++) for (int c = 0; c < NCH; c++) if (m_act[i][c]) busy = 1;
    end
    chk("drain_timeout", 64'(busy), 64'(0));
  endtask

  task automatic chk_wrap_1010(string nm);
    logic [39:0] ea [8];
    ea = '{40'h1010, 40'h1018, 40'h1020, 40'h1028, 40'h1030, 40'h1038, 40'h1000, 40'h1008};
    chk({nm, "_beats"}, 64'(lq_addr.size()), 64'(8));
    for (int j = 0; j < 8 && j < lq_addr.size(); j++) begin
      chk($sformatf("%s_addr%0d", nm, j), 64'(lq_addr[j]), 64'(ea[j]));
      chk($sformatf("%s_lock%0d", nm, j), 64'(lq_lock[j]), 64'(j < 7));
      chk($sformatf("%s_done%0d", nm, j), 64'(lq_done[j]), 64'(j == 7));
    end
  endtask

  initial begin
    mask = '{mem_cmd_payload_mask_gp, mem_resp_payload_mask_gp};
    is_mst = '{1'b1, 1'b0};
    for (int i = 0; i < 2; i++) begin
      own[i] = -1; ptr[i] = 0; mem_yumi[i] = 0; fsm_v[i] = '0; fsm_hdr[i] = '0; fsm_data[i] = '0;
      for (int c = 0; c < NCH; c++) begin
        m_act[i][c] = 0; m_done[i][c] = 0; m_id[i][c] = 0;
        m_typ[i][c] = e_mem_msg_rd; m_size[i][c] = '0; m_addr[i][c] = '0;
      end
    end
    // Reset held with a pending message: every output must stay masked.
    load(0, 0, e_mem_msg_wr, 3'd6, 40'h1010);
    repeat (3) cycle();
    rst_req = 0;

    // 64B write from word 2 wraps through the block.
    clear_log(0);
    drain(40);
    chk_wrap_1010("wr64");

    // Master read without data: one transfer.
    clear_log(0);
    load(0, 1, e_mem_msg_rd, 3'd6, 40'h2000);
    drain(10);
    chk("rd_beats", 64'(lq_addr.size()), 64'(1));
    if (lq_addr.size() == 1) begin
      chk("rd_lock", 64'(lq_lock[0]), 64'(0));
      chk("rd_done", 64'(lq_done[0]), 64'(1));
    end

    // Client write-resp: seven local acks then one combined bus beat.
    clear_log(1);
    load(1, 0, e_mem_msg_wr, 3'd6, 40'h3000);
    drain(20);
    chk("comb_local", 64'(comb_cnt), 64'(7));
    chk("comb_beats", 64'(lq_addr.size()), 64'(1));
    if (lq_addr.size() == 1) chk("comb_done", 64'(lq_done[0]), 64'(1));

    // Two 4-beat messages contend: ch0 streams, ch1 follows with no bubble.
    clear_log(0);
    load(0, 0, e_mem_msg_wr, 3'd5, 40'h4000);
    load(0, 1, e_mem_msg_wr, 3'd5, 40'h5020);
    drain(30);
    chk("rr_beats", 64'(lq_gnt.size()), 64'(8));
    for (int j = 0; j < 8 && j < lq_gnt.size(); j++)
      chk($sformatf("rr_gnt%0d", j), 64'(lq_gnt[j]), 64'(j >= 4));
    if (lq_cyc.size() == 8) chk("rr_no_bubble", 64'(lq_cyc[4] - lq_cyc[3]), 64'(1));

    // After ch0 finishes, the next tie goes to ch1.
    clear_log(0);
    load(0, 0, e_mem_msg_wr, 3'd3, 40'h6000);
    drain(10);
    load(0, 0, e_mem_msg_wr, 3'd3, 40'h6008);
    load(0, 1, e_mem_msg_wr, 3'd3, 40'h7000);
    drain(10);
    chk("tie_beats", 64'(lq_gnt.size()), 64'(3));
    if (lq_gnt.size() == 3) begin
      chk("tie_first", 64'(lq_gnt[0]), 64'(0));
      chk("tie_ch1", 64'(lq_gnt[1]), 64'(1));
    end

    // Stalls on both sides must neither skip nor repeat a beat.
    v_all = 0; yumi_all = 0;
    clear_log(0);
    load(0, 0, e_mem_msg_wr, 3'd6, 40'h1010);
    drain(200);
    chk_wrap_1010("stall");
    v_all = 1; yumi_all = 1;

    // Reset on beat 4 drops the message; it restarts at its first word.
    load(0, 0, e_mem_msg_wr, 3'd6, 40'h1010);
    repeat (3) cycle();
    rst_req = 1;
    cycle();
    rst_req = 0;
    clear_log(0);
    drain(40);
    chk_wrap_1010("rst");

    // Random traffic on both pumps.
    log_sel = -1;
    rand_en = 1; v_all = 0; yumi_all = 0;
    repeat (3000) cycle();
    rand_en = 0;
    drain(2000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
